// File: rtl/mux_nx1_rr.sv
// N-to-1 data multiplexer with a registered valid/ready output stage.
// The source is chosen by an explicit select or by a round-robin arbiter.
module mux_nx1_rr #(
    parameter  int DATA_WIDTH = 16,
    parameter  int CHANNELS   = 4,
    localparam int SEL_W      = $clog2(CHANNELS)
) (
    input  logic                         clock_in,
    input  logic                         reset_n_in,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_data_in,
    input  logic [CHANNELS-1:0]          in_valid_in,
    output logic [CHANNELS-1:0]          in_ready_out,
    input  logic [SEL_W-1:0]             sel_in,
    input  logic                         mode_in,
    output logic [DATA_WIDTH-1:0]        mux_out,
    output logic                         out_valid_out,
    input  logic                         out_ready_in,
    output logic [SEL_W-1:0]             grant_out
);

    logic [SEL_W-1:0]      rr_ptr;
    logic [SEL_W-1:0]      cand;
    logic                  has_cand;
    logic                  load_en;
    logic                  take;
    logic [DATA_WIDTH-1:0] cand_data;

    // The register can accept a new word when it is empty or draining this cycle.
    assign load_en = !out_valid_out || out_ready_in;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        int idx;
        cand     = '0;
        has_cand = 1'b0;
        idx      = 0;
        if (!mode_in) begin
            if (int'(sel_in) < CHANNELS) begin
                cand     = sel_in;
                has_cand = 1'b1;
            end
        end else begin
            // Search starts one past the last granted channel and wraps.
            for (int i = 1; i <= CHANNELS; i++) begin
                idx = (int'(rr_ptr) + i) % CHANNELS;
                if (!has_cand && in_valid_in[idx]) begin
                    cand     = SEL_W'(idx);
                    has_cand = 1'b1;
                end
            end
        end
    end

    always_comb begin
        in_ready_out = '0;
        if (has_cand) begin
            in_ready_out[cand] = load_en;
        end
    end

    assign take      = has_cand && in_valid_in[cand] && load_en;
    assign cand_data = in_data_in[int'(cand)*DATA_WIDTH +: DATA_WIDTH];

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            mux_out       <= '0;
            out_valid_out <= 1'b0;
            grant_out     <= '0;
            rr_ptr        <= SEL_W'(CHANNELS - 1);
        end else if (take) begin
            mux_out       <= cand_data;
            grant_out     <= cand;
            out_valid_out <= 1'b1;
            if (mode_in) begin
                rr_ptr <= cand;
            end
        end else if (out_valid_out && out_ready_in) begin
            out_valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Directed self-checking bench for mux_nx1_rr: a 4-channel and a 3-channel instance.
module tb_mux_nx1_rr;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [63:0] data4;
    logic [3:0]  valid4, ready4;
    logic [1:0]  sel4, grant4;
    logic        mode4, oready4, ovalid4;
    logic [15:0] mux4;

    logic [47:0] data3;
    logic [2:0]  valid3, ready3;
    logic [1:0]  sel3, grant3;
    logic        mode3, oready3, ovalid3;
    logic [15:0] mux3;

    int total  = 0;
    int passed = 0;

    mux_nx1_rr #(.DATA_WIDTH(16), .CHANNELS(4)) dut4 (
        .clock_in(clk), .reset_n_in(rst_n), .in_data_in(data4), .in_valid_in(valid4),
        .in_ready_out(ready4), .sel_in(sel4), .mode_in(mode4), .mux_out(mux4),
        .out_valid_out(ovalid4), .out_ready_in(oready4), .grant_out(grant4)
    );

    mux_nx1_rr #(.DATA_WIDTH(16), .CHANNELS(3)) dut3 (
        .clock_in(clk), .reset_n_in(rst_n), .in_data_in(data3), .in_valid_in(valid3),
        .in_ready_out(ready3), .sel_in(sel3), .mode_in(mode3), .mux_out(mux3),
        .out_valid_out(ovalid3), .out_ready_in(oready3), .grant_out(grant3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data4 = {4{16'hC0DE ^ 16'(i)}};
            data3 = {3{16'h5A5A ^ 16'(i)}};
            valid4 = 4'(i * 5); valid3 = 3'(i * 3);
            sel4 = 2'(i); sel3 = 2'(i);
            mode4 = i[0]; mode3 = i[0];
            oready4 = i[1]; oready3 = i[1];
            step();
        end
        mode4 = 1'b1; valid4 = '0; mode3 = 1'b1; valid3 = '0;
        #1;
        total++; if (mux4 !== 16'h0) $display("FAIL reset_mux: got %h expected %h", mux4, 16'h0); else passed++;
        total++; if (ovalid4 !== 1'b0) $display("FAIL reset_valid: got %b expected 0", ovalid4); else passed++;
        total++; if (grant4 !== 2'd0) $display("FAIL reset_grant: got %0d expected 0", grant4); else passed++;
        total++; if (ready4 !== 4'b0000) $display("FAIL reset_ready: got %b expected 0000", ready4); else passed++;
        total++; if (ovalid3 !== 1'b0) $display("FAIL reset_valid3: got %b expected 0", ovalid3); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_fixed();
        mode4 = 1'b0; sel4 = 2'd2; valid4 = 4'b0100; oready4 = 1'b1;
        data4 = '0; data4[2*16 +: 16] = 16'h0049;
        #1;
        total++; if (ready4 !== 4'b0100) $display("FAIL fixed_ready: got %b expected 0100", ready4); else passed++;
        step();
        total++; if (mux4 !== 16'h0049) $display("FAIL fixed_mux: got %h expected 0049", mux4); else passed++;
        total++; if (grant4 !== 2'd2) $display("FAIL fixed_grant: got %0d expected 2", grant4); else passed++;
        total++; if (ovalid4 !== 1'b1) $display("FAIL fixed_valid: got %b expected 1", ovalid4); else passed++;
        sel4 = 2'd0; valid4 = 4'b0000;
        #1;
        total++; if (ready4 !== 4'b0001) $display("FAIL fixed_sel0_ready: got %b expected 0001", ready4); else passed++;
        step();
        total++; if (ovalid4 !== 1'b0) $display("FAIL fixed_drain_valid: got %b expected 0", ovalid4); else passed++;
        total++; if (mux4 !== 16'h0049) $display("FAIL fixed_drain_mux: got %h expected 0049", mux4); else passed++;
        total++; if (grant4 !== 2'd2) $display("FAIL fixed_drain_grant: got %0d expected 2", grant4); else passed++;
    endtask

    task automatic test_rr_fairness();
        logic [1:0] exp_seq [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [3:0] exp_rdy;
        mode4 = 1'b1; valid4 = 4'b1111; oready4 = 1'b1;
        for (int k = 0; k < 4; k++) data4[k*16 +: 16] = 16'hA000 + 16'(k);
        for (int i = 0; i < 6; i++) begin
            exp_rdy = 4'b0001 << exp_seq[i];
            #1;
            total++; if (ready4 !== exp_rdy) $display("FAIL rr_ready[%0d]: got %b expected %b", i, ready4, exp_rdy); else passed++;
            step();
            total++; if (grant4 !== exp_seq[i]) $display("FAIL rr_grant[%0d]: got %0d expected %0d", i, grant4, exp_seq[i]); else passed++;
            total++; if (mux4 !== 16'hA000 + 16'(exp_seq[i])) $display("FAIL rr_mux[%0d]: got %h expected %h", i, mux4, 16'hA000 + 16'(exp_seq[i])); else passed++;
            total++; if (ovalid4 !== 1'b1) $display("FAIL rr_valid[%0d]: got %b expected 1", i, ovalid4); else passed++;
        end
    endtask

    task automatic test_backpressure();
        mode4 = 1'b0; sel4 = 2'd1; valid4 = 4'b1111; oready4 = 1'b1;
        data4[1*16 +: 16] = 16'hFF49;
        step();
        total++; if (mux4 !== 16'hFF49) $display("FAIL bp_load_mux: got %h expected FF49", mux4); else passed++;
        oready4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data4[1*16 +: 16] = 16'h1100 + 16'(i);
            sel4 = 2'(i);
            #1;
            total++; if (ready4 !== 4'b0000) $display("FAIL bp_ready[%0d]: got %b expected 0000", i, ready4); else passed++;
            step();
            total++; if (mux4 !== 16'hFF49) $display("FAIL bp_mux[%0d]: got %h expected FF49", i, mux4); else passed++;
            total++; if (grant4 !== 2'd1) $display("FAIL bp_grant[%0d]: got %0d expected 1", i, grant4); else passed++;
            total++; if (ovalid4 !== 1'b1) $display("FAIL bp_valid[%0d]: got %b expected 1", i, ovalid4); else passed++;
        end
        sel4 = 2'd3; data4[3*16 +: 16] = 16'h1234; oready4 = 1'b1;
        #1;
        total++; if (ready4 !== 4'b1000) $display("FAIL bp_release_ready: got %b expected 1000", ready4); else passed++;
        step();
        total++; if (mux4 !== 16'h1234) $display("FAIL bp_release_mux: got %h expected 1234", mux4); else passed++;
        total++; if (grant4 !== 2'd3) $display("FAIL bp_release_grant: got %0d expected 3", grant4); else passed++;
        total++; if (ovalid4 !== 1'b1) $display("FAIL bp_release_valid: got %b expected 1", ovalid4); else passed++;
    endtask

    task automatic test_out_of_range();
        mode3 = 1'b0; sel3 = 2'd3; valid3 = 3'b111; oready3 = 1'b1;
        data3 = {16'h0C02, 16'h0C01, 16'h0C00};
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (ready3 !== 3'b000) $display("FAIL oor_ready[%0d]: got %b expected 000", i, ready3); else passed++;
            step();
            total++; if (ovalid3 !== 1'b0) $display("FAIL oor_valid[%0d]: got %b expected 0", i, ovalid3); else passed++;
        end
        sel3 = 2'd2;
        #1;
        total++; if (ready3 !== 3'b100) $display("FAIL oor_sel2_ready: got %b expected 100", ready3); else passed++;
        step();
        total++; if (mux3 !== 16'h0C02) $display("FAIL oor_sel2_mux: got %h expected 0C02", mux3); else passed++;
    endtask

    task automatic test_reset_mid_stream();
        // rr_ptr was left at 1 by the fairness run; fixed transfers since then do not move it.
        mode4 = 1'b1; valid4 = 4'b1111; oready4 = 1'b1;
        #1;
        total++; if (ready4 !== 4'b0100) $display("FAIL mid_pre_ready: got %b expected 0100", ready4); else passed++;
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (mux4 !== 16'h0) $display("FAIL mid_rst_mux: got %h expected 0000", mux4); else passed++;
        total++; if (ovalid4 !== 1'b0) $display("FAIL mid_rst_valid: got %b expected 0", ovalid4); else passed++;
        total++; if (grant4 !== 2'd0) $display("FAIL mid_rst_grant: got %0d expected 0", grant4); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (ready4 !== 4'b0001) $display("FAIL mid_post_ready: got %b expected 0001", ready4); else passed++;
        step();
        total++; if (grant4 !== 2'd0) $display("FAIL mid_post_grant: got %0d expected 0", grant4); else passed++;
        total++; if (mux4 !== 16'hA000) $display("FAIL mid_post_mux: got %h expected A000", mux4); else passed++;
    endtask

    task automatic test_single_requester();
        mode4 = 1'b1; valid4 = 4'b0100; oready4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (grant4 !== 2'd2) $display("FAIL single_grant[%0d]: got %0d expected 2", i, grant4); else passed++;
            total++; if (ovalid4 !== 1'b1) $display("FAIL single_valid[%0d]: got %b expected 1", i, ovalid4); else passed++;
        end
    endtask

    initial begin
        data4 = '0; valid4 = '0; sel4 = '0; mode4 = 1'b0; oready4 = 1'b0;
        data3 = '0; valid3 = '0; sel3 = '0; mode3 = 1'b0; oready3 = 1'b0;
        test_reset();
        test_fixed();
        test_rr_fairness();
        test_backpressure();
        test_out_of_range();
        test_reset_mid_stream();
        test_single_requester();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mux_nx1_rr.md
# mux_nx1_rr

Parametrised N-to-1 data multiplexer with a registered output stage and valid/ready handshaking on every input and on the output, for the BIP2 datapath. It is the successor to the plain combinational 2-to-1 mux:
- channel count and width are parameters;
- the source is picked either by an explicit select (fixed mode) or by a round-robin arbiter;
- selected data is held in an output register until the consumer takes it.

## Interface
- DATA_WIDTH, 16, width of each data word
- CHANNELS, 4, number of input channels (≥2)
- SEL_W, $clog2(CHANNELS), width of select/grant fields (derived, not overridden)

- clock_in  input  1  single clock, rising edge
- reset_n_in  input  1  reset, asynchronous, active-low
- in_data_in  input  CHANNELS*DATA_WIDTH  packed channel data, channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- in_valid_in  input  CHANNELS  per-channel valid
- in_ready_out  output  CHANNELS  per-channel ready (at most one bit high)
- sel_in  input  SEL_W  channel select, used when mode_in=0
- mode_in  input  1  0 = fixed select, 1 = round-robin
- mux_out  output  DATA_WIDTH  registered output data
- out_valid_out  output  1  mux_out holds a word
- out_ready_in  input  1  consumer accepts mux_out
- grant_out  output  SEL_W  channel index that supplied the word currently in mux_out

## Operation
- load_en = !out_valid_out | out_ready_in (register empty or draining this cycle).
- Candidate channel c:
  - Fixed mode: c = sel_in. If sel_in ≥ CHANNELS, there is no candidate.
  - RR mode: first k with in_valid_in[k], searched from rr_ptr+1 upward and wrapping modulo CHANNELS. If no valid input, there is no candidate.
- in_ready_out[c] = load_en when a candidate exists. All other bits are 0. Combinational from out_ready_in, out_valid_out, mode_in, sel_in, in_valid_in and rr_ptr.
- Transfer in: in_valid_in[c] & in_ready_out[c]. On the edge it:
  - loads mux_out ← channel c data;
  - sets grant_out ← c and out_valid_out ← 1;
  - in RR mode only, sets rr_ptr ← c.
- Transfer out: out_valid_out & out_ready_in. On the edge, if there is no simultaneous transfer in, out_valid_out ← 0. mux_out and grant_out keep their last values.
- Simultaneous out and in on the same edge: the new word replaces the old one, out_valid_out stays 1, and no bubble is inserted.
- Fixed-mode transfers never move rr_ptr.
- A change of mode_in or sel_in affects only the next candidate choice. A word already held is never altered.
- While out_valid_out=1 and out_ready_in=0:
  - mux_out, grant_out and out_valid_out are stable;
  - all in_ready_out bits are 0.
- In fixed mode, invalid data on the selected channel is never loaded.

## Timing
- Reset (async assert, sync release on clock_in):
  - mux_out=0, out_valid_out=0, grant_out=0;
  - rr_ptr=CHANNELS-1, so the first RR search starts at channel 0;
  - in_ready_out follows its combinational rule, so all bits are 0 when there is no candidate.
- Latency: input accepted at edge n, data visible on mux_out after edge n.
- Throughput: one word per cycle with out_ready_in held at 1.
- Reset asserted mid-transfer: the held word is discarded and outputs go to reset values immediately, without waiting for a clock edge.
- RR wrap: with rr_ptr=CHANNELS-1, the search order is 0,1,…,CHANNELS-1.
- Single requester in RR mode: that channel is granted every cycle.

## Test plan
- Reset: assert reset_n_in=0 with all inputs toggling -> mux_out=0, out_valid_out=0, grant_out=0; in_ready_out=0 when no channel is valid.
- Fixed mode, CHANNELS=4: ch2 data=16'h0049 valid, sel_in=2, out_ready_in=1 -> in_ready_out=4'b0100. Next cycle mux_out=16'h0049, grant_out=2, out_valid_out=1. Switch sel_in=0 with ch0 invalid -> out_valid_out drops after one cycle.
- RR fairness: all four channels valid continuously with distinct data, out_ready_in=1 -> grant_out sequence 0,1,2,3,0,1, one word per cycle.
- Backpressure: hold out_ready_in=0 with word 16'hFF49 loaded -> mux_out and grant_out stable, in_ready_out=0 for ≥3 cycles. Release -> the next candidate loads on the same edge the old word drains.
- Out-of-range select: CHANNELS=3, fixed mode, sel_in=3, all valid -> in_ready_out=0 and out_valid_out stays 0.
- Reset mid-stream: RR streaming with rr_ptr=1, assert reset_n_in between edges -> outputs go to 0 at once. After release, first grant is ch0.
